// File: rtl/data_mem_bhw.sv
// rtl/data_mem_bhw.sv - word-organised byte/half/word data memory with 1-cycle response
// Array is swept to zero after reset when CLEAR_ON_RESET=1.
module data_mem_bhw #(
  parameter int ADDR_WIDTH     = 10,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_unsigned,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [31:0]           req_wdata,
  output logic                  rsp_valid,
  output logic [31:0]           rsp_rdata,
  output logic                  rsp_err
);

  localparam int WW    = ADDR_WIDTH - 2;
  localparam int DEPTH = 1 << WW;

  typedef enum logic {S_CLEAR, S_READY} state_t;

  state_t      state;
  logic [WW-1:0] cnt;
  logic [31:0] mem [DEPTH];

  logic          accept;
  logic [WW-1:0] idx;
  logic [1:0]    lane;
  logic          misaligned;
  logic [3:0]    be;
  logic [31:0]   wd_sh;
  logic [31:0]   rd_word;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_val;

  assign accept = req_valid & req_ready;
  assign idx    = req_addr[ADDR_WIDTH-1:2];
  assign lane   = req_addr[1:0];

  assign misaligned = (req_size == 2'b11) ||
                      (req_size == 2'b01 && lane[0]) ||
                      (req_size == 2'b10 && lane != 2'b00);

  always_comb begin
    be      = 4'b0000;
    wd_sh   = '0;
    ld_val  = '0;
    rd_word = mem[idx];
    byte_v  = rd_word[{lane, 3'b000} +: 8];
    half_v  = lane[1] ? rd_word[31:16] : rd_word[15:0];
    case (req_size)
      2'b00: begin
        be     = 4'b0001 << lane;
        wd_sh  = {4{req_wdata[7:0]}};
        ld_val = {{24{~req_unsigned & byte_v[7]}}, byte_v};
      end
      2'b01: begin
        be     = lane[1] ? 4'b1100 : 4'b0011;
        wd_sh  = {2{req_wdata[15:0]}};
        ld_val = {{16{~req_unsigned & half_v[15]}}, half_v};
      end
      2'b10: begin
        be     = 4'b1111;
        wd_sh  = req_wdata;
        ld_val = rd_word;
      end
      default: ;
    endcase
  end

  // Array has no reset of its own; the CLEAR sweep provides the zeroing.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == S_CLEAR) begin
        mem[cnt] <= '0;
      end else if (accept && req_we && !misaligned) begin
        for (int i = 0; i < 4; i++) begin
          if (be[i]) mem[idx][8*i +: 8] <= wd_sh[8*i +: 8];
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= CLEAR_ON_RESET ? S_CLEAR : S_READY;
      cnt       <= '0;
      req_ready <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_CLEAR: begin
          cnt <= cnt + WW'(1);
          if (cnt == WW'(DEPTH - 1)) begin
            state     <= S_READY;
            req_ready <= 1'b1;
          end
        end
        default: req_ready <= 1'b1;
      endcase
      rsp_valid <= accept;
      rsp_err   <= accept & misaligned;
      rsp_rdata <= (accept && !misaligned && !req_we) ? ld_val : '0;
    end
  end

endmodule

// File: tb/tb_data_mem_bhw.sv
// tb/tb_data_mem_bhw.sv - directed and random bench for data_mem_bhw against a byte-array model
module tb_data_mem_bhw;
  localparam int AW    = 6;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [1:0]    req_size;
  logic          req_unsigned;
  logic [AW-1:0] req_addr;
  logic [31:0]   req_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;

  always #5 clk = ~clk;

  data_mem_bhw #(.ADDR_WIDTH(AW), .CLEAR_ON_RESET(1'b1)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [7:0]  ref_mem [64];
  logic        exp_v, exp_ready, exp_e;
  logic [31:0] exp_d;
  int          clr;
  string       prev_tag;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Memory as a flat byte array; alignment means address is a multiple of the access size.
  function automatic void model(input logic we, input logic [1:0] sz, input logic un,
                                input logic [5:0] ad, input logic [31:0] wd,
                                output logic [31:0] d, output logic e);
    int n;
    logic [31:0] val;
    n = 1 << sz;
    e = (sz == 2'b11) || ((int'(ad) % n) != 0);
    d = '0;
    if (e) return;
    if (we) begin
      for (int i = 0; i < n; i++) ref_mem[int'(ad) + i] = wd[8*i +: 8];
    end else begin
      val = '0;
      for (int i = 0; i < n; i++) val[8*i +: 8] = ref_mem[int'(ad) + i];
      if (!un && n < 4 && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8*n));
      d = val;
    end
  endfunction

  task automatic cycle(input string tag, input logic v, input logic we, input logic [1:0] sz,
                       input logic un, input logic [5:0] ad, input logic [31:0] wd);
    check({prev_tag, " ready"}, 32'(req_ready), 32'(exp_ready));
    check({prev_tag, " valid"}, 32'(rsp_valid), 32'(exp_v));
    if (exp_v) begin
      check({prev_tag, " rdata"}, rsp_rdata, exp_d);
      check({prev_tag, " err"}, 32'(rsp_err), 32'(exp_e));
    end
    prev_tag     = tag;
    req_valid    = v;
    req_we       = we;
    req_size     = sz;
    req_unsigned = un;
    req_addr     = ad;
    req_wdata    = wd;
    if (v && exp_ready && !rst) begin
      model(we, sz, un, ad, wd, exp_d, exp_e);
      exp_v = 1'b1;
    end else begin
      exp_v = 1'b0;
    end
    @(posedge clk);
    if (rst) begin
      clr       = 0;
      exp_ready = 1'b0;
      exp_v     = 1'b0;
      for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    end else begin
      if (clr < DEPTH) clr++;
      exp_ready = (clr == DEPTH);
    end
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = '0; req_wdata = '0;
    exp_v = 1'b0; exp_ready = 1'b0; exp_e = 1'b0; exp_d = '0; clr = 0;
    prev_tag = "reset";
    for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    @(posedge clk);
    @(negedge clk);
    check("reset rdata", rsp_rdata, 32'h0);
    check("reset err", 32'(rsp_err), 32'h0);
    cycle("reset", 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
    rst = 1'b0;

    // Request held during the clear sweep: no accept until ready rises.
    for (int i = 0; i < DEPTH; i++) cycle("clear_hold", 1'b1, 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0);
    cycle("ldw_3c", 1'b1, 1'b0, 2'b10, 1'b0, 6'h3C, 32'h0);

    cycle("stw_10",  1'b1, 1'b1, 2'b10, 1'b0, 6'h10, 32'h80FF7F01);
    cycle("ldb_10",  1'b1, 1'b0, 2'b00, 1'b0, 6'h10, 32'h0);
    cycle("ldbu_11", 1'b1, 1'b0, 2'b00, 1'b1, 6'h11, 32'h0);
    cycle("ldh_12",  1'b1, 1'b0, 2'b01, 1'b0, 6'h12, 32'h0);
    cycle("ldw_10",  1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);

    cycle("stw_20",  1'b1, 1'b1, 2'b10, 1'b0, 6'h20, 32'h11223344);
    cycle("stb_21",  1'b1, 1'b1, 2'b00, 1'b0, 6'h21, 32'h000000AA);
    cycle("ldw_20a", 1'b1, 1'b0, 2'b10, 1'b0, 6'h20, 32'h0);
    cycle("sth_22",  1'b1, 1'b1, 2'b01, 1'b0, 6'h22, 32'h0000BEEF);
    cycle("ldw_20b", 1'b1, 1'b0, 2'b10, 1'b0, 6'h20, 32'h0);

    cycle("stw_04",   1'b1, 1'b1, 2'b10, 1'b0, 6'h04, 32'hCAFEF00D);
    cycle("ldh_03e",  1'b1, 1'b0, 2'b01, 1'b0, 6'h03, 32'h0);
    cycle("stw_06e",  1'b1, 1'b1, 2'b10, 1'b0, 6'h06, 32'h12345678);
    cycle("sz3_00e",  1'b1, 1'b0, 2'b11, 1'b0, 6'h00, 32'h0);
    cycle("ldw_04",   1'b1, 1'b0, 2'b10, 1'b0, 6'h04, 32'h0);

    cycle("stw_08",  1'b1, 1'b1, 2'b10, 1'b0, 6'h08, 32'hA5A55A5A);
    cycle("ldw_08",  1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    cycle("idle",    1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);

    // Reset right after a load accept: the response is dropped and the sweep repeats.
    cycle("ldw_08b", 1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    rst = 1'b1;
    cycle("rst_mid", 1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) cycle("reclear", 1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    cycle("ldw_08z", 1'b1, 1'b0, 2'b10, 1'b0, 6'h08, 32'h0);
    cycle("ldw_10z", 1'b1, 1'b0, 2'b10, 1'b0, 6'h10, 32'h0);

    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 199) == 0);
      cycle("rand", ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
            2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            6'($urandom_range(0, 63)), $urandom);
    end
    rst = 1'b0;
    cycle("flush", 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);
    cycle("end", 1'b0, 1'b0, 2'b00, 1'b0, 6'h00, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_bhw.md
Name: data_mem_bhw

Overview:
- Parametrised successor to the 8-bit, 64-entry data memory.
- Word-organised RAM serving byte, halfword and word loads/stores for the RV32IM load/store unit, with a request/response handshake.
- Sign/zero extension and misalignment detection are done internally.
- A hardware clear sequence zeroes the array after reset, so large depths do not need a per-entry reset.

Parameters:
- ADDR_WIDTH, 10, byte-address width; the array holds 2**(ADDR_WIDTH-2) 32-bit words (min 3).
- CLEAR_ON_RESET, 1, if 1 the array is swept to zero after reset; if 0 the block is ready immediately after reset and contents are undefined.

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block accepts a request this cycle
- req_we  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 half, 10 word, 11 illegal
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend
- req_addr  in  ADDR_WIDTH  byte address
- req_wdata  in  32  store data, LSB-justified
- rsp_valid  out  1  one-cycle pulse, response for the accepted request
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  misaligned or illegal-size request, qualified by rsp_valid

Behaviour:
- One clock (clk); reset (rst) is synchronous and active-high.
- Reset values: req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0. The FSM enters CLEAR, or READY if CLEAR_ON_RESET=0. The clear counter is set to 0.
- FSM states:
  - CLEAR: writes word[cnt]=0 each cycle, cnt increments; req_ready=0. After writing the last word (cnt = DEPTH-1), go to READY on the next edge. Total clear time is 2**(ADDR_WIDTH-2) cycles after rst deasserts.
  - READY: req_ready=1 continuously.
- Accept = req_valid & req_ready. Requests are never accepted in CLEAR.
- Latency: exactly 1 cycle. rsp_valid=1 in the cycle after accept with rsp_rdata/rsp_err registered. rsp_valid=0 in every cycle not following an accept. No downstream backpressure.
- Full throughput: one accept per cycle, back-to-back.
- Word index = req_addr[ADDR_WIDTH-1:2]; lane = req_addr[1:0].
- Misaligned (rsp_err=1, no memory update, rdata=0):
  - half with addr[0]=1
  - word with addr[1:0]!=0
  - any size 11
- Stores update only the addressed lanes at the accept edge:
  - byte: wdata[7:0] into lane
  - half: wdata[15:0] into lanes {addr[1],0}..+1, little-endian
  - word: all four lanes
  - Untouched lanes keep their value.
- Loads:
  - byte: lane extended from bit 7
  - half: little-endian halfword extended from bit 15
  - word: unchanged
  - Extension uses req_unsigned as captured at accept.
- Read-after-write: a load accepted the cycle after a store to the same word returns the updated data. No forwarding is needed because the write has already committed at the accept edge of the store.
- A store and load to the same address cannot be simultaneous (single port).
- rst asserted mid-operation: any pending response is dropped (rsp_valid=0 next cycle). The clear restarts from word 0. Contents are re-zeroed if CLEAR_ON_RESET=1.
- Address wrap: not applicable; the full address space maps to the array.

Test Plan:
- Release rst with ADDR_WIDTH=6, CLEAR_ON_RESET=1 -> req_ready=0 for 16 cycles, then 1. A load word at 0x3C returns 0x00000000, rsp_err=0.
- Store word 0x80FF7F01 at 0x10, then back-to-back loads at 0x10 (byte signed), 0x11 (byte unsigned), 0x12 (half signed), 0x10 (word):
  - expect 0x00000001, 0x0000007F, 0xFFFF80FF, 0x80FF7F01
  - one response per cycle, each 1 cycle after accept
- Store byte 0xAA at 0x21 over word 0x11223344 -> word reads 0x1122AA44. Store half 0xBEEF at 0x22 -> word reads 0xBEEFAA44.
- Half load at 0x03, word store at 0x06, size 11 at 0x00 -> each gives rsp_err=1, rsp_rdata=0. A later load of word 0x04 shows its value unchanged.
- Store word at 0x08 then load it in the next cycle -> new data returned. req_valid held high with req_ready=0 during CLEAR -> no rsp_valid pulses.
- Assert rst for 1 cycle immediately after a load accept -> no rsp_valid, req_ready=0, full clear repeats, previously written data reads back as 0.
